// File: rtl/iic_pll_apb_master.sv
// APB initiator for the iic_pll dynamic-reconfiguration port.
// Accepts one command at a time, runs a single SETUP/ACCESS transfer with a
// timeout, and returns a one-cycle response pulse carrying read data and an
// error flag.
// Optional feature: define IIC_PLL_LOCK_WAIT_EN to wait for PLL relock after
// each successful write before responding.
module iic_pll_apb_master #(
   parameter int unsigned ADDR_W        = 5,
   parameter int unsigned DATA_W        = 16,
   parameter int unsigned TIMEOUT_CYC   = 255,
   parameter int unsigned LOCK_WAIT_CYC = 4095
) (
   input  logic              apb_clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic [ADDR_W-1:0] apb_addr,
   output logic              apb_sel,
   output logic              apb_en,
   output logic              apb_write,
   output logic [DATA_W-1:0] apb_wdata,
   input  logic [DATA_W-1:0] apb_rdata,
   input  logic              apb_ready,
   input  logic              lock
);

`ifdef IIC_PLL_LOCK_WAIT_EN
   typedef enum logic [2:0] {StIdle, StSetup, StAccess, StResp, StLockWait} state_e;
`else
   typedef enum logic [2:0] {StIdle, StSetup, StAccess, StResp} state_e;
`endif

   localparam logic [15:0] TmoLimit = 16'(TIMEOUT_CYC);

   state_e      state;
   logic [15:0] tmo_cnt;
   logic [15:0] tmo_next;
   logic        lock_s1;
   logic        lock_s;

   assign tmo_next = tmo_cnt + 16'd1;

`ifdef IIC_PLL_LOCK_WAIT_EN
   localparam logic [15:0] LockLimit = 16'(LOCK_WAIT_CYC);

   logic [15:0] lw_cnt;
   logic [15:0] lw_next;
   logic [2:0]  run_cnt;
   logic [2:0]  run_next;

   assign lw_next = lw_cnt + 16'd1;

   // Consecutive-cycles-locked counter, saturating at 4.
   always_comb begin
      run_next = 3'd0;
      if (lock_s) begin
         run_next = (run_cnt == 3'd4) ? 3'd4 : run_cnt + 3'd1;
      end
   end
`else
   // Lock is synchronised but not consumed in this build.
   logic unused_lock;
   assign unused_lock = lock_s | (LOCK_WAIT_CYC == 32'd0);
`endif

   // Two-flop synchroniser for the asynchronous PLL lock.
   always_ff @(posedge apb_clk) begin
      if (rst) begin
         lock_s1 <= 1'b0;
         lock_s  <= 1'b0;
      end else begin
         lock_s1 <= lock;
         lock_s  <= lock_s1;
      end
   end

   // Transfer FSM with all outputs registered.
   always_ff @(posedge apb_clk) begin
      if (rst) begin
         state     <= StIdle;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         apb_sel   <= 1'b0;
         apb_en    <= 1'b0;
         apb_write <= 1'b0;
         apb_addr  <= '0;
         apb_wdata <= '0;
         tmo_cnt   <= '0;
`ifdef IIC_PLL_LOCK_WAIT_EN
         lw_cnt    <= '0;
         run_cnt   <= '0;
`endif
      end else begin
         rsp_valid <= 1'b0;
         unique case (state)
            StIdle: begin
               if (cmd_valid && cmd_ready) begin
                  apb_write <= cmd_write;
                  apb_addr  <= cmd_addr;
                  apb_wdata <= cmd_wdata;
                  apb_sel   <= 1'b1;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  tmo_cnt   <= '0;
                  state     <= StSetup;
               end
            end
            StSetup: begin
               apb_en <= 1'b1;
               state  <= StAccess;
            end
            StAccess: begin
               tmo_cnt <= tmo_next;
               // Ready takes priority over a timeout on the same edge.
               if (apb_ready) begin
                  apb_sel <= 1'b0;
                  apb_en  <= 1'b0;
`ifdef IIC_PLL_LOCK_WAIT_EN
                  if (apb_write) begin
                     lw_cnt  <= '0;
                     run_cnt <= '0;
                     state   <= StLockWait;
                  end else begin
                     rsp_rdata <= apb_rdata;
                     rsp_err   <= 1'b0;
                     rsp_valid <= 1'b1;
                     state     <= StResp;
                  end
`else
                  rsp_rdata <= apb_write ? '0 : apb_rdata;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= StResp;
`endif
               end else if (tmo_next == TmoLimit) begin
                  apb_sel   <= 1'b0;
                  apb_en    <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= StResp;
               end
            end
            StResp: begin
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= StIdle;
            end
`ifdef IIC_PLL_LOCK_WAIT_EN
            StLockWait: begin
               lw_cnt  <= lw_next;
               run_cnt <= run_next;
               if (run_next == 3'd4) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= StResp;
               end else if (lw_next == LockLimit) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= StResp;
               end
            end
`endif
            default: begin
               apb_sel   <= 1'b0;
               apb_en    <= 1'b0;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iic_pll_apb_master.sv
// Self-checking bench for iic_pll_apb_master: directed and randomized
// transfers against a latency/result model derived from the transfer rules.
module tb_iic_pll_apb_master;

   localparam int TMO  = 8;
   localparam int LWC  = 64;

   logic        apb_clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [4:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic [4:0]  apb_addr;
   logic        apb_sel;
   logic        apb_en;
   logic        apb_write;
   logic [15:0] apb_wdata;
   logic [15:0] apb_rdata;
   logic        apb_ready;
   logic        lock;

   int checks   = 0;
   int failures = 0;

   // Responder: raises ready after wait_n ACCESS cycles of the current transfer.
   int          wait_n = 0;
   int          acc_cnt = 0;
   logic        ready_force = 1'b0;
   logic [15:0] rd_val = '0;

   // Expected request fields, checked by the protocol monitor.
   logic        in_txn = 1'b0;
   logic        exp_wr;
   logic [4:0]  exp_addr;
   logic [15:0] exp_wdata;
   int          proto_err = 0;

   iic_pll_apb_master #(
      .ADDR_W       (5),
      .DATA_W       (16),
      .TIMEOUT_CYC  (TMO),
      .LOCK_WAIT_CYC(LWC)
   ) dut (
      .apb_clk  (apb_clk),
      .rst      (rst),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err),
      .busy     (busy),
      .apb_addr (apb_addr),
      .apb_sel  (apb_sel),
      .apb_en   (apb_en),
      .apb_write(apb_write),
      .apb_wdata(apb_wdata),
      .apb_rdata(apb_rdata),
      .apb_ready(apb_ready),
      .lock     (lock)
   );

   initial begin
      apb_clk = 1'b0;
      forever #5 apb_clk = ~apb_clk;
   end

   assign apb_ready = ready_force | (apb_sel & apb_en & (acc_cnt == wait_n));
   assign apb_rdata = rd_val;

   always @(posedge apb_clk) begin
      if (apb_sel && apb_en && !apb_ready) acc_cnt <= acc_cnt + 1;
      else                                 acc_cnt <= 0;
   end

   always @(negedge apb_clk) begin
      if (!rst) begin
         if (apb_en && !apb_sel) proto_err <= proto_err + 1;
         if (in_txn && apb_sel &&
             (apb_write !== exp_wr || apb_addr !== exp_addr || apb_wdata !== exp_wdata))
            proto_err <= proto_err + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one command; returns at the negedge of the SETUP cycle.
   task automatic send_cmd(input logic wr, input logic [4:0] a, input logic [15:0] d);
      @(negedge apb_clk);
      chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      exp_wr    = wr;
      exp_addr  = a;
      exp_wdata = d;
      @(negedge apb_clk);
      in_txn    = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = 5'($urandom);
      cmd_wdata = 16'($urandom);
      chk("setup_sel_en", {30'd0, apb_sel, apb_en}, 32'd2);
   endtask

   // Counts cycles from accept edge to the response cycle (bounded).
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 400) begin
         @(negedge apb_clk);
         lat++;
      end
      chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
      in_txn = 1'b0;
   endtask

   task automatic do_txn(input string tag, input logic wr, input logic [4:0] a,
                         input logic [15:0] d, input int wn, input logic [15:0] rd);
      int          lat;
      int          exp_lat;
      logic        exp_err;
      logic [15:0] exp_rd;
      // Model: ready after wn wait cycles unless the timeout budget runs out.
      if (wn >= TMO) begin
         exp_err = 1'b1;
         exp_rd  = '0;
         exp_lat = 2 + TMO;
      end else begin
         exp_err = 1'b0;
         exp_rd  = wr ? 16'h0 : rd;
         exp_lat = 3 + wn;
`ifdef IIC_PLL_LOCK_WAIT_EN
         if (wr) exp_lat += 4;
`endif
      end
      wait_n = wn;
      rd_val = rd;
      send_cmd(wr, a, d);
      wait_rsp(lat);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      chk({tag, "_rdata"}, {16'd0, rsp_rdata}, {16'd0, exp_rd});
      chk({tag, "_resp_bus"}, {28'd0, apb_sel, apb_en, cmd_ready, busy}, 32'd1);
      @(negedge apb_clk);
      chk({tag, "_pulse"}, {30'd0, rsp_valid, cmd_ready}, 32'd1);
      chk({tag, "_hold"}, {15'd0, rsp_err, rsp_rdata}, {15'd0, exp_err, exp_rd});
   endtask

   initial begin
      int n_rsp;
      int lat;
      int rise;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      lock      = 1'b1;
      repeat (3) @(negedge apb_clk);
      chk("reset_state", {25'd0, cmd_ready, apb_sel, apb_en, rsp_valid, busy, rsp_err, 1'b0},
          32'h40);
      chk("reset_rdata", {16'd0, rsp_rdata}, 32'd0);
      rst = 1'b0;

      // Zero-wait write with ready held high.
      ready_force = 1'b1;
      do_txn("wr0", 1'b1, 5'h03, 16'hA55A, 0, 16'hFFFF);
      ready_force = 1'b0;

      do_txn("rd2", 1'b0, 5'h07, 16'h0000, 2, 16'h1234);
      do_txn("tmo", 1'b0, 5'h11, 16'h0000, 1000, 16'hBEEF);
      // Ready on the last allowed ACCESS cycle beats the timeout.
      do_txn("edge", 1'b0, 5'h1F, 16'h0000, TMO - 1, 16'hC0DE);

      // Reset during the second ACCESS cycle.
      wait_n = 1000;
      send_cmd(1'b0, 5'h05, 16'h0);
      @(negedge apb_clk);
      @(negedge apb_clk);
      rst    = 1'b1;
      in_txn = 1'b0;
      @(negedge apb_clk);
      chk("rst_mid", {28'd0, apb_sel, apb_en, rsp_valid, cmd_ready}, 32'd1);
      rst   = 1'b0;
      n_rsp = 0;
      repeat (12) begin
         @(negedge apb_clk);
         if (rsp_valid === 1'b1) n_rsp++;
      end
      chk("rst_mid_no_rsp", n_rsp, 0);

      // Randomized transfers.
      for (int i = 0; i < 20; i++) begin
         do_txn("rnd", 1'($urandom), 5'($urandom), 16'($urandom), $urandom_range(0, 10),
                16'($urandom));
      end

`ifdef IIC_PLL_LOCK_WAIT_EN
      // Relock after 20 cycles.
      lock   = 1'b0;
      wait_n = 0;
      repeat (4) @(negedge apb_clk);
      send_cmd(1'b1, 5'h09, 16'h5A5A);
      lat  = 1;
      rise = 0;
      while (rsp_valid !== 1'b1 && lat < 400) begin
         if (lat == 20) begin
            lock = 1'b1;
            rise = lat;
         end
         @(negedge apb_clk);
         lat++;
      end
      in_txn = 1'b0;
      chk("lock_rsp_seen", {31'd0, rsp_valid}, 32'd1);
      chk("lock_delay_ok", {31'd0, (lat - rise) >= 6}, 32'd1);
      chk("lock_err", {31'd0, rsp_err}, 32'd0);

      // Lock never returns.
      lock = 1'b0;
      repeat (4) @(negedge apb_clk);
      send_cmd(1'b1, 5'h0A, 16'h1111);
      wait_rsp(lat);
      chk("lockto_lat", lat, 3 + LWC);
      chk("lockto_err", {31'd0, rsp_err}, 32'd1);
      chk("lockto_rdata", {16'd0, rsp_rdata}, 32'd0);
      lock = 1'b1;
`endif

      @(negedge apb_clk);
      chk("protocol", proto_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
